fpu_issue_arbiter: RTL and testbench
====================================

Name: fpu_issue_arbiter

Overview:
- Shares the single FP execution unit (sign-inject, add/mul, div/sqrt paths) between two requesters, e.g. the integer-pipe FP issue port and the FP load/convert sequencer.
- Round-robin grants one request at a time and latches its operands and FUNC.
- Issues a one-cycle start to the FP unit, then collects the result.
- Single-cycle FUNCs (FSGNJ/FSGNJN/FSGNJX = 11/12/13) complete in the issue cycle; all other FUNCs wait for FPU_DONE, bounded by a timeout.

Parameters:
- DATA_W, 32, operand/result width
- FUNC_W, 4, FP function code width
- TIMEOUT_CYC, 64, max cycles in WAIT before aborting (>=2)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ0_VALID  in  1  requester 0 has an op
- REQ0_READY  out  1  requester 0 op accepted this cycle
- REQ0_OP_A  in  DATA_W  rs1 value
- REQ0_OP_B  in  DATA_W  rs2 value
- REQ0_FUNC  in  FUNC_W  FP function code
- REQ1_VALID / REQ1_READY / REQ1_OP_A / REQ1_OP_B / REQ1_FUNC  same as requester 0
- FPU_START  out  1  one-cycle launch pulse
- FPU_OP_A  out  DATA_W  latched operand A
- FPU_OP_B  out  DATA_W  latched operand B
- FPU_FUNC  out  FUNC_W  latched FUNC
- FPU_DONE  in  1  multi-cycle op finished
- FPU_RESULT  in  DATA_W  FP unit result; valid with FPU_DONE, or combinationally for single-cycle FUNCs
- RSP0_VALID  out  1  result pulse for requester 0
- RSP1_VALID  out  1  result pulse for requester 1
- RSP_DATA  out  DATA_W  result, valid with RSPx_VALID
- RSP_ERR  out  1  timeout flag, valid with RSPx_VALID
- BUSY  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - State IDLE, last_grant=1 (requester 0 wins first), timeout counter 0.
  - FPU_OP_A/B=0, FPU_FUNC=0, RSP_DATA=0.
  - All VALID/READY/START/ERR/BUSY outputs 0.
- States: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - If any REQx_VALID, grant one requester.
  - READY is combinational, asserted only to the granted requester, and only in IDLE.
  - On grant: latch OP_A, OP_B, FUNC and the owner; go to EXEC.
- Arbitration:
  - One request valid: grant it.
  - Both valid: grant the requester != last_grant.
  - last_grant updates at the grant.
- EXEC:
  - FPU_START=1 for exactly this cycle.
  - Single-cycle FUNC (11/12/13): capture FPU_RESULT into RSP_DATA, ERR=0, go to RESP.
  - Other FUNC with FPU_DONE=1 this cycle: capture FPU_RESULT, go to RESP.
  - Otherwise clear the counter and go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - FPU_DONE=1: capture FPU_RESULT, ERR=0, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 without DONE: RSP_DATA=0, ERR=1, go to RESP.
  - DONE and the timeout in the same cycle: DONE wins.
- RESP:
  - RSPx_VALID=1 to the owner for exactly one cycle; no back-pressure.
  - Go to IDLE. A new grant is possible on the next cycle.
- Latency:
  - Single-cycle op: accepted at T, START at T+1, RSP at T+2.
  - Multi-cycle op with DONE at T+1+k (k>=1): RSP at T+2+k.
  - Throughput: at most one op per 3 cycles.
- FPU_OP_A/B/FUNC hold their latched values from grant until the next grant.
- FPU_DONE outside EXEC/WAIT is ignored; a stale DONE never produces a response.
- FPU_START never asserts outside EXEC.
- RST mid-operation: abort immediately to the reset values, with no response for the in-flight op. A DONE arriving after reset is ignored.
- Requesters hold VALID and their operands until READY; the arbiter never drops a held request.
- No starvation: with both requesters continuously valid, grants alternate 0,1,0,1.

Decomposition:
- Shared package fpu_pkg:
  - FUNC code constants FSGNJ=11, FSGNJN=12, FSGNJX=13.
  - Arbiter state encoding.
  - Function is_single_cycle(func).
- Sub-module rr_arb2: two-input round-robin arbiter holding last_grant, with inputs req[1:0] and enable, and output one-hot grant.

Test Plan:
- Reset, then REQ0 FSGNJ A=0x3F800000, B=0x80000000 -> READY0 at T, START at T+1, RSP0_VALID at T+2 with RSP_DATA=0xBF800000, ERR=0.
- REQ0 and REQ1 both valid continuously, FUNC=12 -> grants 0,1,0,1. RSP0/RSP1 alternate every 3 cycles, never both high.
- REQ1 multi-cycle FUNC=3, FPU_DONE at START+5 with RESULT=0x40490FDB -> RSP1_VALID one cycle after DONE, data 0x40490FDB, BUSY high throughout.
- Multi-cycle op, FPU_DONE never asserted, TIMEOUT_CYC=8 -> RSP with RSP_DATA=0, ERR=1 after 8 WAIT cycles, then IDLE.
- RST pulsed in WAIT, then FPU_DONE two cycles later -> no RSP, all outputs at reset values. Next request is served normally, requester 0 first.
- Spurious FPU_DONE in IDLE, and FPU_DONE in the same cycle as the timeout -> the first is ignored; the second responds with ERR=0 and the FPU_RESULT data.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue arbiter: sign-inject FUNC codes, arbiter states,
// and the single-cycle FUNC classifier.
package fpu_pkg;

    localparam logic [31:0] FSGNJ  = 32'd11;
    localparam logic [31:0] FSGNJN = 32'd12;
    localparam logic [31:0] FSGNJX = 32'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // Sign-inject ops finish combinationally inside the FP unit.
    function automatic logic is_single_cycle(input logic [31:0] func);
        return (func == FSGNJ) || (func == FSGNJN) || (func == FSGNJX);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; combinational one-hot grant while enabled.
// On contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Reset to 1 so requester 0 wins the first contended grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (|o_grant) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one FP execution unit between two requesters: grant, latch operands, pulse start,
// collect the result (single-cycle FUNCs in the issue cycle, others on DONE or timeout).
module fpu_issue_arbiter
    import fpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FUNC_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [DATA_W-1:0] i_req0_op_a,
    input  logic [DATA_W-1:0] i_req0_op_b,
    input  logic [FUNC_W-1:0] i_req0_func,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req1_op_a,
    input  logic [DATA_W-1:0] i_req1_op_b,
    input  logic [FUNC_W-1:0] i_req1_func,
    output logic              o_fpu_start,
    output logic [DATA_W-1:0] o_fpu_op_a,
    output logic [DATA_W-1:0] o_fpu_op_b,
    output logic [FUNC_W-1:0] o_fpu_func,
    input  logic              i_fpu_done,
    input  logic [DATA_W-1:0] i_fpu_result,
    output logic              o_rsp0_valid,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t        r_state;
    logic              r_owner;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [FUNC_W-1:0] r_func;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_start;
    logic              r_rsp0;
    logic              r_rsp1;
    logic              r_err;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        w_grant;
    logic              w_arb_en;
    logic              w_single;
    logic              w_timeout;

    assign w_arb_en  = (r_state == ST_IDLE);
    assign w_single  = is_single_cycle(32'(r_func));
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    rr_arb2 u_rr_arb2 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   ({i_req1_valid, i_req0_valid}),
        .i_en    (w_arb_en),
        .o_grant (w_grant)
    );

    assign o_req0_ready = w_grant[0];
    assign o_req1_ready = w_grant[1];
    assign o_fpu_start  = r_start;
    assign o_fpu_op_a   = r_op_a;
    assign o_fpu_op_b   = r_op_b;
    assign o_fpu_func   = r_func;
    assign o_rsp0_valid = r_rsp0;
    assign o_rsp1_valid = r_rsp1;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_err    = r_err;
    assign o_busy       = r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_func     <= '0;
            r_rsp_data <= '0;
            r_start    <= 1'b0;
            r_rsp0     <= 1'b0;
            r_rsp1     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_start <= 1'b0;
            r_rsp0  <= 1'b0;
            r_rsp1  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_owner <= w_grant[1];
                        r_op_a  <= w_grant[1] ? i_req1_op_a : i_req0_op_a;
                        r_op_b  <= w_grant[1] ? i_req1_op_b : i_req0_op_b;
                        r_func  <= w_grant[1] ? i_req1_func : i_req0_func;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= '0;
                    if (w_single || i_fpu_done) begin
                        r_rsp_data <= i_fpu_result;
                        r_rsp0     <= ~r_owner;
                        r_rsp1     <= r_owner;
                        r_state    <= ST_RESP;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // DONE is checked first so it wins over a coincident timeout.
                    if (i_fpu_done) begin
                        r_rsp_data <= i_fpu_result;
                        r_rsp0     <= ~r_owner;
                        r_rsp1     <= r_owner;
                        r_state    <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_err      <= 1'b1;
                        r_rsp0     <= ~r_owner;
                        r_rsp1     <= r_owner;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: directed scenarios then random traffic, checked each cycle
// against a transaction-timing model (grant cycle -> start/response cycles by arithmetic).
module tb_fpu_issue_arbiter;

    localparam int DW = 32;
    localparam int FW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
    logic [FW-1:0] req0_func = '0, req1_func = '0;
    logic          fpu_start;
    logic [DW-1:0] fpu_op_a, fpu_op_b;
    logic [FW-1:0] fpu_func;
    logic          fpu_done = 1'b0;
    logic [DW-1:0] fpu_result = '0;
    logic          rsp0_valid, rsp1_valid, rsp_err, busy;
    logic [DW-1:0] rsp_data;

    fpu_issue_arbiter #(.DATA_W(DW), .FUNC_W(FW), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_op_a(req0_op_a), .i_req0_op_b(req0_op_b), .i_req0_func(req0_func),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_op_a(req1_op_a), .i_req1_op_b(req1_op_b), .i_req1_func(req1_func),
        .o_fpu_start(fpu_start), .o_fpu_op_a(fpu_op_a), .o_fpu_op_b(fpu_op_b),
        .o_fpu_func(fpu_func), .i_fpu_done(fpu_done), .i_fpu_result(fpu_result),
        .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Requester stimulus: held until accepted.
    logic        rq_vld [2];
    logic [31:0] rq_a [2], rq_b [2];
    logic [3:0]  rq_f [2];
    logic [1:0]  rq_en = 2'b00;
    int          refill = 0;

    // Reference model: cycle numbers of the in-flight op's events.
    int          free_at = 0, last = 1, owner = 0, st_cyc = -1, rsp_cyc = -1, done_cyc = -1;
    logic [31:0] m_a = '0, m_b = '0, exp_dat = '0, done_res = '0;
    logic [3:0]  m_f = '0;
    logic        exp_err = 1'b0;
    int          force_j = -1;
    logic [31:0] force_res = '0;
    bit          force_spur = 0;

    int          obs_rsp_cyc = -1, obs_owner = 0, obs_start_cyc = -1, last_grant_cyc = -1;
    logic [31:0] obs_dat = '0;
    logic        obs_err = 1'b0;
    int          grant_log[$];
    int          rsp_log[$];

    function automatic bit is_sc(input logic [3:0] f);
        return (f == 4'd11) || (f == 4'd12) || (f == 4'd13);
    endfunction

    function automatic logic [31:0] sgnj(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = a;
        if (f == 4'd11)      r[31] = b[31];
        else if (f == 4'd12) r[31] = ~b[31];
        else                 r[31] = a[31] ^ b[31];
        return r;
    endfunction

    task automatic new_op(input int r);
        rq_a[r] = $urandom;
        rq_b[r] = $urandom;
        if (refill == 2) begin
            rq_f[r] = 4'd12;
            rq_vld[r] = 1'b1;
        end else if (refill == 1) begin
            rq_f[r] = 4'($urandom_range(0, 15));
            rq_vld[r] = ($urandom_range(0, 2) != 0);
        end else begin
            rq_vld[r] = 1'b0;
        end
    endtask

    task automatic step(input bit do_rst, input bit keep_done);
        bit v0, v1, idle, in_op, use_force;
        int g, j;
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < 2; r++)
            if (refill == 1 && !rq_vld[r] && $urandom_range(0, 2) == 0) begin
                new_op(r);
                rq_vld[r] = 1'b1;
            end
        v0 = rq_vld[0] & rq_en[0];
        v1 = rq_vld[1] & rq_en[1];
        req0_valid = v0; req0_op_a = rq_a[0]; req0_op_b = rq_b[0]; req0_func = rq_f[0];
        req1_valid = v1; req1_op_a = rq_a[1]; req1_op_b = rq_b[1]; req1_func = rq_f[1];
        rst = do_rst;
        idle = (cyc >= free_at);
        g = -1;
        if (idle && !do_rst && (v0 || v1)) g = (v0 && v1) ? 1 - last : (v0 ? 0 : 1);
        in_op = (cyc >= st_cyc) && (cyc < rsp_cyc);
        fpu_done = 1'b0;
        fpu_result = $urandom;
        if (cyc == done_cyc) begin
            fpu_done = 1'b1;
            fpu_result = done_res;
        end else if (cyc == st_cyc && is_sc(m_f)) begin
            fpu_result = sgnj(m_f, m_a, m_b);
        end else if (!in_op && (force_spur || $urandom_range(0, 5) == 0)) begin
            fpu_done = 1'b1;
        end
        force_spur = 0;

        @(negedge clk);
        if (!do_rst) begin
            check_eq("ready0", req0_ready, g == 0);
            check_eq("ready1", req1_ready, g == 1);
            check_eq("start", fpu_start, cyc == st_cyc);
            check_eq("busy", busy, cyc >= st_cyc && cyc <= rsp_cyc);
            check_eq("rsp0", rsp0_valid, cyc == rsp_cyc && owner == 0);
            check_eq("rsp1", rsp1_valid, cyc == rsp_cyc && owner == 1);
            check_eq("fpu_op_a", fpu_op_a, m_a);
            check_eq("fpu_op_b", fpu_op_b, m_b);
            check_eq("fpu_func", fpu_func, m_f);
            if (cyc == rsp_cyc) begin
                check_eq("rsp_data", rsp_data, exp_dat);
                check_eq("rsp_err", rsp_err, exp_err);
            end
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
                obs_rsp_cyc = cyc;
                obs_owner = (rsp1_valid === 1'b1) ? 1 : 0;
                obs_dat = rsp_data;
                obs_err = rsp_err;
                rsp_log.push_back(cyc);
            end
            if (req0_ready === 1'b1) begin grant_log.push_back(0); last_grant_cyc = cyc; end
            if (req1_ready === 1'b1) begin grant_log.push_back(1); last_grant_cyc = cyc; end
            if (fpu_start === 1'b1) obs_start_cyc = cyc;
        end

        if (do_rst) begin
            free_at = cyc + 1; last = 1; st_cyc = -1; rsp_cyc = -1;
            m_a = '0; m_b = '0; m_f = '0;
            if (!keep_done) done_cyc = -1;
        end else if (g >= 0) begin
            owner = g; last = g;
            m_a = rq_a[g]; m_b = rq_b[g]; m_f = rq_f[g];
            st_cyc = cyc + 1;
            done_cyc = -1;
            if (is_sc(m_f)) begin
                rsp_cyc = st_cyc + 1; exp_dat = sgnj(m_f, m_a, m_b); exp_err = 1'b0;
            end else begin
                use_force = (force_j >= 0);
                j = use_force ? force_j : $urandom_range(0, TO + 3);
                force_j = -1;
                if (j <= TO) begin
                    done_cyc = st_cyc + j;
                    done_res = use_force ? force_res : $urandom;
                    rsp_cyc = st_cyc + 1 + j; exp_dat = done_res; exp_err = 1'b0;
                end else begin
                    rsp_cyc = st_cyc + 1 + TO; exp_dat = '0; exp_err = 1'b1;
                end
            end
            free_at = rsp_cyc + 1;
            new_op(g);
        end
    endtask

    task automatic run_rsp(input string tag, input int max);
        obs_rsp_cyc = -1;
        for (int i = 0; i < max; i++) begin
            step(0, 0);
            if (obs_rsp_cyc >= 0) break;
        end
        check_eq(tag, obs_rsp_cyc >= 0, 1'b1);
    endtask

    initial begin
        int s0;
        logic [31:0] t6_res;
        for (int r = 0; r < 2; r++) begin
            rq_vld[r] = 1'b0; rq_a[r] = '0; rq_b[r] = '0; rq_f[r] = '0;
        end

        repeat (2) step(1, 0);
        step(0, 0);
        check_eq("rst_op_a", fpu_op_a, 32'h0);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        check_eq("rst_err", rsp_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);

        // Single-cycle FSGNJ from requester 0.
        rq_a[0] = 32'h3F800000; rq_b[0] = 32'h80000000; rq_f[0] = 4'd11; rq_vld[0] = 1'b1;
        rq_en = 2'b01;
        run_rsp("t1_rsp_seen", 20);
        check_eq("t1_start_lat", obs_start_cyc - last_grant_cyc, 1);
        check_eq("t1_rsp_lat", obs_rsp_cyc - last_grant_cyc, 2);
        check_eq("t1_data", obs_dat, 32'hBF800000);
        check_eq("t1_err", obs_err, 1'b0);
        check_eq("t1_owner", obs_owner, 0);
        repeat (2) step(0, 0);

        // Both requesters continuously valid: alternating grants, responses every 3 cycles.
        grant_log.delete(); rsp_log.delete();
        rq_en = 2'b11; refill = 2;
        new_op(0); new_op(1);
        repeat (14) step(0, 0);
        refill = 0;
        repeat (10) step(0, 0);
        check_eq("t2_ngrants", grant_log.size() >= 4, 1'b1);
        for (int i = 1; i < grant_log.size(); i++)
            check_eq("t2_alternate", grant_log[i], 1 - grant_log[i-1]);
        for (int i = 1; i < rsp_log.size() && i < 4; i++)
            check_eq("t2_rsp_gap", rsp_log[i] - rsp_log[i-1], 3);

        // Multi-cycle op on requester 1, DONE 5 cycles after start.
        rq_a[1] = $urandom; rq_b[1] = $urandom; rq_f[1] = 4'd3; rq_vld[1] = 1'b1;
        rq_en = 2'b10; force_j = 5; force_res = 32'h40490FDB;
        run_rsp("t3_rsp_seen", 30);
        check_eq("t3_owner", obs_owner, 1);
        check_eq("t3_data", obs_dat, 32'h40490FDB);
        check_eq("t3_err", obs_err, 1'b0);
        check_eq("t3_lat", obs_rsp_cyc - obs_start_cyc, 6);
        repeat (2) step(0, 0);

        // DONE never arrives: timeout after TO wait cycles.
        rq_a[0] = $urandom; rq_b[0] = $urandom; rq_f[0] = 4'd7; rq_vld[0] = 1'b1;
        rq_en = 2'b01; force_j = 99;
        run_rsp("t4_rsp_seen", 40);
        check_eq("t4_err", obs_err, 1'b1);
        check_eq("t4_data", obs_dat, 32'h0);
        check_eq("t4_lat", obs_rsp_cyc - obs_start_cyc, TO + 1);
        repeat (2) step(0, 0);
        check_eq("t4_idle", busy, 1'b0);

        // Reset while waiting, stale DONE two cycles later.
        rq_a[0] = $urandom; rq_b[0] = $urandom; rq_f[0] = 4'd3; rq_vld[0] = 1'b1;
        rq_en = 2'b01; force_j = 4;
        s0 = st_cyc;
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            if (st_cyc != s0 && cyc >= st_cyc + 1) break;
        end
        rq_en = 2'b00;
        obs_rsp_cyc = -1;
        step(1, 1);
        repeat (6) step(0, 0);
        check_eq("t5_no_rsp", obs_rsp_cyc, -1);
        check_eq("t5_op_a", fpu_op_a, 32'h0);
        check_eq("t5_func", fpu_func, 4'h0);
        check_eq("t5_busy", busy, 1'b0);
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            rq_a[r] = $urandom; rq_b[r] = $urandom; rq_f[r] = 4'd13; rq_vld[r] = 1'b1;
        end
        rq_en = 2'b11;
        step(0, 0);
        check_eq("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : 9, 0);
        repeat (10) step(0, 0);

        // Spurious DONE in idle, then DONE coinciding with the timeout cycle.
        force_spur = 1;
        obs_rsp_cyc = -1;
        step(0, 0);
        check_eq("t6_spurious", obs_rsp_cyc, -1);
        t6_res = $urandom;
        rq_a[0] = $urandom; rq_b[0] = $urandom; rq_f[0] = 4'd5; rq_vld[0] = 1'b1;
        rq_en = 2'b01; force_j = TO; force_res = t6_res;
        run_rsp("t6_rsp_seen", 40);
        check_eq("t6_err", obs_err, 1'b0);
        check_eq("t6_data", obs_dat, t6_res);
        check_eq("t6_lat", obs_rsp_cyc - obs_start_cyc, TO + 1);
        repeat (2) step(0, 0);

        // Random traffic with occasional resets.
        refill = 1; rq_en = 2'b11;
        new_op(0); new_op(1);
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 199) == 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
